game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 24 ++
 rtl/game_ctrl_if.sv | 26 ++
 rtl/game_timer.sv | 28 ++
 rtl/game_ctrl.sv | 173 +++++++++++++++++
 tb/tb_game_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the memory-game controller.
package game_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StInput,
        StWin,
        StFail,
        StOver
    } game_state_e;

    localparam logic [3:0] KEY_START = 4'h5;
    localparam logic [3:0] KEY_END   = 4'hF;
    localparam logic [3:0] KEY_NONE  = 4'h0;

    // Nibble idx of a sequence word; index 0 is the MSB nibble.
    function automatic logic [3:0] seq_nibble(input logic [15:0] seq, input logic [1:0] idx);
        logic [15:0] shifted;
        shifted = seq << {idx, 2'b00};
        return shifted[15:12];
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Keypad / matcher / display bundle around the game controller.
interface game_ctrl_if;
    logic [3:0]  key_pressed;
    logic [15:0] key_seq;
    logic        seq_done;
    logic [3:0]  show_key;
    logic        input_en;
    logic        seq_clr;
    logic        level_up;
    logic        lose_life;
    logic [1:0]  lives;
    logic        game_over;
    logic [7:0]  score;

    // Environment side: keypad, level generator and matcher.
    modport master (
        output key_pressed, key_seq, seq_done,
        input  show_key, input_en, seq_clr, level_up, lose_life, lives, game_over, score
    );

    // Controller side.
    modport slave (
        input  key_pressed, key_seq, seq_done,
        output show_key, input_en, seq_clr, level_up, lose_life, lives, game_over, score
    );
endinterface

// File: rtl/game_timer.sv
// Loadable down-counter with enable and zero flag; holds at zero.
module game_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    // Load has priority over counting; never wraps below zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/game_ctrl.sv
// Memory-game round controller: playback, input window, win/fail, game over.
// Optional score counter enabled by defining GAME_CTRL_SCORE_EN.
// Pulses (seq_clr, level_up, lose_life) are registered from the next state, so
// level_up/lose_life coincide with the WIN/FAIL cycle and the start/INPUT-entry
// seq_clr appears in the first cycle of the state being entered.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50_000_000,
    parameter int unsigned SHOW_CYC    = 25_000_000,
    parameter int unsigned LIVES       = 3
) (
    input logic        clk,
    input logic        reset,
    game_ctrl_if.slave bus
);

    localparam logic [31:0] SHOW_LOAD    = 32'(SHOW_CYC - 1);
    localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYC - 1);
    localparam logic [1:0]  LIVES_INIT   = 2'(LIVES);

    game_state_e state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  lives_q, lives_d;
    logic        show_load, show_en, show_zero;
    logic        input_load, input_cnt_en, input_zero;
    logic [3:0]  cur_key, next_key;
    logic        seq_clr_q, level_up_q, lose_life_q;

    assign cur_key  = seq_nibble(bus.key_seq, idx_q);
    assign next_key = seq_nibble(bus.key_seq, idx_q + 2'd1);

    game_timer #(.WIDTH(32)) u_show_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (show_load),
        .en       (show_en),
        .load_val (SHOW_LOAD),
        .zero     (show_zero)
    );

    game_timer #(.WIDTH(32)) u_input_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (input_load),
        .en       (input_cnt_en),
        .load_val (TIMEOUT_LOAD),
        .zero     (input_zero)
    );

    // Next-state, playback index, lives and timer controls.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        lives_d      = lives_q;
        show_load    = 1'b0;
        show_en      = 1'b0;
        input_load   = 1'b0;
        input_cnt_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.key_pressed == KEY_START) begin
                    state_d   = StPlay;
                    idx_d     = 2'd0;
                    show_load = 1'b1;
                end
            end
            StPlay: begin
                if (cur_key == KEY_END) begin
                    // Only reachable at index 0: empty sequence skips playback.
                    state_d    = StInput;
                    input_load = 1'b1;
                end else if (show_zero) begin
                    if ((idx_q == 2'd3) || (next_key == KEY_END)) begin
                        state_d    = StInput;
                        input_load = 1'b1;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        show_load = 1'b1;
                    end
                end else begin
                    show_en = 1'b1;
                end
            end
            StInput: begin
                // A match in the expiry cycle still counts as a win.
                if (bus.seq_done) begin
                    state_d = StWin;
                end else if (input_zero) begin
                    state_d = StFail;
                    lives_d = lives_q - 2'd1;
                end else begin
                    input_cnt_en = 1'b1;
                end
            end
            StWin: begin
                state_d   = StPlay;
                idx_d     = 2'd0;
                show_load = 1'b1;
            end
            StFail: begin
                state_d   = (lives_q == 2'd0) ? StOver : StPlay;
                idx_d     = 2'd0;
                show_load = 1'b1;
            end
            StOver: begin
                if (bus.key_pressed == KEY_START) begin
                    state_d = StIdle;
                    lives_d = LIVES_INIT;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, index and lives registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            lives_q <= LIVES_INIT;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lives_q <= lives_d;
        end
    end

    // One-cycle pulses registered from the upcoming transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_clr_q   <= 1'b0;
            level_up_q  <= 1'b0;
            lose_life_q <= 1'b0;
        end else begin
            seq_clr_q   <= (state_d == StWin) || (state_d == StFail) ||
                           ((state_q == StIdle) && (state_d == StPlay)) ||
                           ((state_q == StPlay) && (state_d == StInput));
            level_up_q  <= (state_d == StWin);
            lose_life_q <= (state_d == StFail);
        end
    end

`ifdef GAME_CTRL_SCORE_EN
    logic [7:0] score_q;

    // Rounds won, saturating; cleared when leaving OVER.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score_q <= 8'd0;
        end else if ((state_q == StOver) && (state_d == StIdle)) begin
            score_q <= 8'd0;
        end else if ((state_d == StWin) && (score_q != 8'hFF)) begin
            score_q <= score_q + 8'd1;
        end
    end

    assign bus.score = score_q;
`else
    assign bus.score = 8'd0;
`endif

    assign bus.show_key  = ((state_q == StPlay) && (cur_key != KEY_END)) ? cur_key : KEY_NONE;
    assign bus.input_en  = (state_q == StInput);
    assign bus.game_over = (state_q == StOver);
    assign bus.lives     = lives_q;
    assign bus.seq_clr   = seq_clr_q;
    assign bus.level_up  = level_up_q;
    assign bus.lose_life = lose_life_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomised self-checking bench for game_ctrl with a round-level model.
module tb_game_ctrl;

    localparam int SHOW = 4;
    localparam int TMO  = 20;
    localparam int NLIV = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    game_ctrl_if bus ();

    game_ctrl #(
        .TIMEOUT_CYC (TMO),
        .SHOW_CYC    (SHOW),
        .LIVES       (NLIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          exp_lives;
    int          exp_score;
    logic [15:0] cur_seq;
    logic [3:0]  exp_keys[$];
    logic [18:0] got, want;

    function automatic logic [7:0] score_exp();
`ifdef GAME_CTRL_SCORE_EN
        return (exp_score > 255) ? 8'hFF : 8'(exp_score);
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [18:0] obs();
        return {bus.show_key, bus.input_en, bus.seq_clr, bus.level_up, bus.lose_life,
                bus.lives, bus.game_over, bus.score};
    endfunction

    function automatic logic [18:0] expv(input logic [3:0] sk, input logic ie, input logic sc,
                                         input logic lu, input logic ll, input logic go);
        return {sk, ie, sc, lu, ll, 2'(exp_lives), go, score_exp()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Keys the player is shown: leading nibbles up to the first F, at most four.
    task automatic model_keys(input logic [15:0] seq);
        logic [3:0] nib;
        exp_keys.delete();
        for (int i = 0; i < 4; i++) begin
            nib = 4'((seq >> (12 - 4 * i)) & 16'hF);
            if (nib == 4'hF) break;
            exp_keys.push_back(nib);
        end
    endtask

    function automatic logic [15:0] random_seq();
        logic [15:0] s;
        int          n;
        s = 16'hFFFF;
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) s[15 - 4 * i -: 4] = 4'($urandom_range(1, 14));
        return s;
    endfunction

    // Entered on the first PLAY cycle; leaves on the first INPUT cycle.
    task automatic run_playback(input logic first_clr);
        model_keys(cur_seq);
        if (exp_keys.size() == 0) begin
            got = obs(); want = expv(4'h0, 1'b0, first_clr, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL play_empty seq=%h got=%h want=%h", cur_seq, got, want);
            end
            step();
        end else begin
            for (int i = 0; i < exp_keys.size() * SHOW; i++) begin
                got = obs();
                want = expv(exp_keys[i / SHOW], 1'b0, first_clr && (i == 0), 1'b0, 1'b0, 1'b0);
                n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL play seq=%h cyc=%0d got=%h want=%h", cur_seq, i, got, want);
                end
                bus.key_pressed = 4'($urandom_range(0, 15));
                step();
            end
            bus.key_pressed = 4'h0;
        end
        got = obs(); want = expv(4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL input_entry seq=%h got=%h want=%h", cur_seq, got, want);
        end
    endtask

    // Entered on INPUT cycle 1; win_at=0 means never match. Ends in PLAY or OVER.
    task automatic run_input(input int win_at, input logic [15:0] next_seq, output bit over);
        bit won;
        won  = 1'b0;
        over = 1'b0;
        for (int c = 1; c <= TMO; c++) begin
            if (c > 1) begin
                got = obs(); want = expv(4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL input_hold cyc=%0d got=%h want=%h", c, got, want);
                end
            end
            bus.seq_done = (c == win_at);
            if (c > 2) bus.key_pressed = 4'h5;
            step();
            bus.key_pressed = 4'h0;
            if (c == win_at) begin
                won = 1'b1;
                break;
            end
        end
        bus.seq_done = 1'b0;
        if (won) begin
            exp_score++;
            got = obs(); want = expv(4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL win at=%0d got=%h want=%h", win_at, got, want);
            end
            cur_seq = next_seq;
            bus.key_seq = cur_seq;
            step();
        end else begin
            exp_lives--;
            got = obs(); want = expv(4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL timeout got=%h want=%h", got, want);
            end
            step();
            if (exp_lives == 0) begin
                over = 1'b1;
                got = obs(); want = expv(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL game_over got=%h want=%h", got, want);
                end
            end
        end
    endtask

    task automatic start_game(input logic [15:0] seq);
        cur_seq = seq;
        bus.key_seq = seq;
        bus.key_pressed = 4'h5;
        step();
        bus.key_pressed = 4'h0;
        run_playback(1'b1);
    endtask

    task automatic test_reset();
        bus.key_pressed = 4'h0;
        bus.key_seq = 16'hFFFF;
        bus.seq_done = 1'b0;
        #2 reset = 1'b0;
        exp_lives = NLIV;
        exp_score = 0;
        step();
        got = obs(); want = expv(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_values got=%h want=%h", got, want);
        end
        reset = 1'b1;
        // Non-start keys must not leave IDLE.
        for (int i = 0; i < 4; i++) begin
            bus.key_pressed = 4'(i == 1 ? 9 : i);
            step();
            got = obs(); want = expv(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL idle_hold key=%0d got=%h want=%h", i, got, want);
            end
        end
        bus.key_pressed = 4'h0;
    endtask

    task automatic restart_game();
        bus.key_pressed = 4'h3;
        step();
        got = obs(); want = expv(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL over_hold got=%h want=%h", got, want);
        end
        bus.key_pressed = 4'h5;
        step();
        bus.key_pressed = 4'h0;
        exp_lives = NLIV;
        exp_score = 0;
        got = obs(); want = expv(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL restart got=%h want=%h", got, want);
        end
    endtask

    task automatic test_scenario();
        bit over;
        start_game(16'h32FF);
        run_input(5, 16'h32FF, over);             // win at INPUT cycle 5
        run_playback(1'b0);
        run_input(0, 16'h0000, over);             // timeout, lives 3->2, same sequence
        run_playback(1'b0);
        run_input(TMO, 16'hA1B4, over);           // match in the expiry cycle
        run_playback(1'b0);
        run_input(0, 16'h0000, over);
        run_playback(1'b0);
        run_input(0, 16'h0000, over);
        if (!over) begin
            n_fail++;
            $display("FAIL over_reached got=0 want=1");
        end
        restart_game();
        start_game(16'hFFFF);                     // empty sequence
        run_input(1, 16'h7FFF, over);
        run_playback(1'b0);
    endtask

    task automatic test_random();
        bit over;
        int w;
        for (int r = 0; r < 14; r++) begin
            w = $urandom_range(1, TMO);
            if ($urandom_range(0, 2) == 0) w = 0;
            run_input(w, random_seq(), over);
            if (over) begin
                restart_game();
                start_game(random_seq());
            end else begin
                run_playback(1'b0);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit dummy;
        dummy = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        exp_lives = NLIV;
        exp_score = 0;
        got = obs(); want = expv(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL mid_reset got=%h want=%h", got, want);
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            got = obs(); want = expv(4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL post_reset cyc=%0d got=%h want=%h", i, got, want);
            end
        end
        if (dummy) $display("unused");
    endtask

    initial begin
        test_reset();
        test_scenario();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
